bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 140 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method.
// One bit per cycle; results are held under a valid/ready handshake until consumed.
module bin2bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_signed,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*DIGITS-1:0]          out_bcd,
  output logic                         out_neg,
  output logic [$clog2(DIGITS+1)-1:0]  out_ndigits
);

  localparam int CntW      = $clog2(WIDTH + 1);
  localparam int NdW       = $clog2(DIGITS + 1);
  localparam int MinDigits = (WIDTH * 30103 + 99999) / 100000;

  // Too few digits would let the top digit overflow silently during the shifts.
  generate
    if (WIDTH < 2 || WIDTH > 64 || DIGITS < MinDigits) begin : g_param_check
      $error("bin2bcd_seq: WIDTH must be 2..64 and DIGITS >= ceil(WIDTH*0.30103)");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e                 state_q;
  logic                   in_ready_q;
  logic [WIDTH-1:0]       mag_q;
  logic [4*DIGITS-1:0]    bcd_q;
  logic [CntW-1:0]        cnt_q;
  logic                   neg_q;
  logic                   out_valid_q;
  logic [4*DIGITS-1:0]    out_bcd_q;
  logic                   out_neg_q;
  logic [NdW-1:0]         out_nd_q;

  logic [WIDTH-1:0]       mag_d;
  logic [4*DIGITS-1:0]    bcd_d;
  logic [4*DIGITS-1:0]    adj;
  logic [3:0]             digit;
  logic                   cap_neg;
  logic [WIDTH-1:0]       cap_mag;
  logic [NdW-1:0]         nd_d;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is exactly its magnitude.
  always_comb begin
    cap_neg = in_signed & in_data[WIDTH-1];
    cap_mag = cap_neg ? (~in_data + WIDTH'(1)) : in_data;
  end

  always_comb begin
    adj   = '0;
    digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = bcd_q[4*i +: 4];
      adj[4*i +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end
    {bcd_d, mag_d} = {adj, mag_q} << 1;
  end

  always_comb begin
    nd_d = NdW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        nd_d = NdW'(i + 1);
      end
    end
  end

  // The first DONE cycle publishes the accumulator into the output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      mag_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_neg_q   <= 1'b0;
      out_nd_q    <= NdW'(1);
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mag_q      <= cap_mag;
            neg_q      <= cap_neg;
            bcd_q      <= '0;
            cnt_q      <= CntW'(WIDTH);
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          mag_q <= mag_d;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_bcd_q   <= bcd_q;
            out_neg_q   <= neg_q && (bcd_q != '0);
            out_nd_q    <= nd_d;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_bcd     = out_bcd_q;
  assign out_neg     = out_neg_q;
  assign out_ndigits = out_nd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized scoreboard bench for bin2bcd_seq: expected results come from a decimal
// arithmetic model, and a monitor compares them whenever a result is presented.
module tb_bin2bcd_seq;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;

  typedef struct {
    logic [4*DIGITS-1:0] bcd;
    logic                neg;
    logic [3:0]          nd;
    int                  acceptEdge;
  } exp_t;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_data;
  logic                in_signed;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] out_bcd;
  logic                out_neg;
  logic [3:0]          out_ndigits;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cycle = 0;
  int   readyMode = 0;
  bit   prevValid = 0;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
    .out_neg(out_neg), .out_ndigits(out_ndigits)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Consumer: 0 = always ready, 1 = random ready, 2 = stalled.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom % 2);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cycle);
  endtask

  // Reference: magnitude by plain arithmetic, then decimal digits by division.
  function automatic exp_t makeExpected(input logic [WIDTH-1:0] data, input logic sgn);
    exp_t e;
    longint unsigned mag;
    longint unsigned d;
    e.neg = sgn && data[WIDTH-1];
    mag = e.neg ? (64'd1 << WIDTH) - longint'(data) : longint'(data);
    e.bcd = '0;
    e.nd = 4'd1;
    e.acceptEdge = 0;
    for (int i = 0; i < DIGITS; i++) begin
      d = mag % 10;
      e.bcd[4*i +: 4] = 4'(d);
      if (d != 0) e.nd = 4'(i + 1);
      mag = mag / 10;
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic sgn,
                               input bit track, output int acceptEdge);
    exp_t e;
    int   waitCnt = 0;
    e = makeExpected(data, sgn);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_data   = data;
    in_signed = sgn;
    @(negedge clk);
    while (!in_ready && waitCnt < 300) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      acceptEdge = cycle;
      return;
    end
    @(posedge clk); #1;
    acceptEdge = cycle;
    e.acceptEdge = cycle;
    if (track) sb.push_back(e);
    for (int i = 0; i < 3; i++) begin
      in_data   = $urandom;
      in_signed = 1'($urandom % 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      prevValid = 0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 64'(out_valid), 64'd0);
        end else begin
          if (!prevValid) checkOutput("latency", 64'(cycle - sb[0].acceptEdge), 64'(WIDTH + 1));
          checkOutput("bcd", 64'(out_bcd), 64'(sb[0].bcd));
          checkOutput("neg", 64'(out_neg), 64'(sb[0].neg));
          checkOutput("ndigits", 64'(out_ndigits), 64'(sb[0].nd));
          if (out_ready) void'(sb.pop_front());
        end
      end
      prevValid = out_valid && !out_ready;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  logic [WIDTH-1:0] dirData[8] = '{32'd255, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h80000000,
                                   32'd0, 32'd0, 32'd9, 32'd1000000000};
  logic             dirSgn[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int ae;
    logic [WIDTH-1:0] d;
    rst = 1; in_valid = 0; in_data = '0; in_signed = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_bcd", 64'(out_bcd), 64'd0);
    checkOutput("reset_out_neg", 64'(out_neg), 64'd0);
    checkOutput("reset_ndigits", 64'(out_ndigits), 64'd1);

    for (int i = 0; i < 8; i++) applyStimulus(dirData[i], dirSgn[i], 1, ae);
    waitDrain();

    // Stall the consumer for 20 cycles in DONE, then release it.
    readyMode = 2;
    @(posedge clk);
    applyStimulus(32'd12345, 1'b0, 1, ae);
    begin
      int n = 0;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
    end
    for (int i = 0; i < 20; i++) begin
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    readyMode = 0;
    begin
      int n = 0;
      while (!out_ready && n < 10) begin @(negedge clk); n++; end
    end
    @(negedge clk);
    checkOutput("release_out_valid", 64'(out_valid), 64'd0);
    checkOutput("release_in_ready", 64'(in_ready), 64'd1);

    readyMode = 1;
    for (int i = 0; i < 25; i++) begin
      d = $urandom;
      d = d >> $urandom_range(0, 31);
      applyStimulus(d, 1'($urandom % 2), 1, ae);
    end
    waitDrain();

    // Abort a conversion mid-shift; reset also coincides with a presented input.
    readyMode = 0;
    applyStimulus(32'd987654321, 1'b0, 0, ae);
    while (cycle < ae + 9) @(posedge clk);
    #1 rst = 1; in_valid = 1; in_data = 32'd99; in_signed = 0;
    @(posedge clk);
    #1 rst = 0; in_valid = 0;
    @(negedge clk);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_out_bcd", 64'(out_bcd), 64'd0);
    checkOutput("abort_out_neg", 64'(out_neg), 64'd0);
    checkOutput("abort_ndigits", 64'(out_ndigits), 64'd1);
    applyStimulus(32'd42, 1'b0, 1, ae);
    waitDrain();
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
